// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, one bit per cycle on
//               operand magnitudes, single-cycle done/write-enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_flush,
    input  logic [2:0]                i_funct3,
    input  logic [DATA_WIDTH-1:0]     i_rs1,
    input  logic [DATA_WIDTH-1:0]     i_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_we,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_calc  = 2'd1;
    localparam logic [1:0]    c_st_done  = 2'd2;
    localparam logic [CW-1:0] c_cnt_load = CW'(W);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_funct3;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [W-1:0]              r_opb;
    logic [W-1:0]              r_rs1;
    logic [2*W-1:0]            r_acc;
    logic                      r_neg_q;
    logic                      r_neg_r;
    logic                      r_div_zero;
    logic                      r_ovf;
    logic [W-1:0]              r_result;

    logic           w_accept;
    logic           w_a_signed;
    logic           w_b_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W:0]     w_mul_sum;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W-1:0]   w_sub;
    logic [2*W-1:0] w_acc_next;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_final;

    assign w_accept   = (r_state == c_st_idle) && i_start && !i_flush;
    assign w_a_signed = i_funct3[2] ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
    assign w_b_signed = w_a_signed && (i_funct3 != 3'b010);
    assign w_a_neg    = w_a_signed && i_rs1[W-1];
    assign w_b_neg    = w_b_signed && i_rs2[W-1];
    assign w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
    assign w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;

    // Multiply: accumulate into the upper half, shift multiplier bits out of the lower half.
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign w_shift = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_ge    = w_shift >= {1'b0, r_opb};
    assign w_sub   = w_shift[W-1:0] - r_opb;

    assign w_acc_next = r_funct3[2]
                      ? {(w_ge ? w_sub : w_shift[W-1:0]), r_acc[W-2:0], w_ge}
                      : {w_mul_sum, r_acc[W-1:1]};

    assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_quot = w_acc_next[W-1:0];
    assign w_rem  = w_acc_next[2*W-1:W];

    always_comb begin
        w_final = w_prod[W-1:0];
        case (r_funct3)
            3'b000: w_final = w_prod[W-1:0];
            3'b001,
            3'b010,
            3'b011: w_final = w_prod[2*W-1:W];
            3'b100,
            3'b101: begin
                if (r_div_zero)   w_final = {W{1'b1}};
                else if (r_ovf)   w_final = {1'b1, {(W-1){1'b0}}};
                else              w_final = r_neg_q ? -w_quot : w_quot;
            end
            default: begin
                if (r_div_zero)   w_final = r_rs1;
                else if (r_ovf)   w_final = {W{1'b0}};
                else              w_final = r_neg_r ? -w_rem : w_rem;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (i_start) w_state_next = c_st_calc;
                c_st_calc: if (r_cnt == c_cnt_one) w_state_next = c_st_done;
                c_st_done: w_state_next = c_st_idle;
                default:   w_state_next = c_st_idle;
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state != c_st_idle);
        o_done = (r_state == c_st_done);
        o_we   = o_done && (r_rd_addr != {REG_ADDR_WIDTH{1'b0}});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= {CW{1'b0}};
            r_funct3   <= 3'b000;
            r_rd_addr  <= {REG_ADDR_WIDTH{1'b0}};
            r_opb      <= {W{1'b0}};
            r_rs1      <= {W{1'b0}};
            r_acc      <= {(2*W){1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= {W{1'b0}};
        end else if (w_accept) begin
            r_cnt      <= c_cnt_load;
            r_funct3   <= i_funct3;
            r_rd_addr  <= i_rd_addr;
            r_rs1      <= i_rs1;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= (i_rs2 == {W{1'b0}});
            r_ovf      <= w_a_signed && w_b_signed
                          && (i_rs1 == {1'b1, {(W-1){1'b0}}}) && (i_rs2 == {W{1'b1}});
            if (i_funct3[2]) begin
                r_opb <= w_b_mag;
                r_acc <= {{W{1'b0}}, w_a_mag};
            end else begin
                r_opb <= w_a_mag;
                r_acc <= {{W{1'b0}}, w_b_mag};
            end
        end else if (r_state == c_st_calc) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - c_cnt_one;
            // An aborted operation must leave the previous result visible.
            if ((r_cnt == c_cnt_one) && !i_flush) r_result <= w_final;
        end
    end

    assign o_rd_addr = r_rd_addr;
    assign o_result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Randomized scoreboard bench for muldiv_unit: expectations are queued at issue
// and checked by an independent monitor whenever o_done pulses.
module tb_muldiv_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, we;
    logic [4:0]  rd_out;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_flush   (flush),
        .i_funct3  (funct3),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_rd_addr (rd_addr),
        .o_busy    (busy),
        .o_done    (done),
        .o_we      (we),
        .o_rd_addr (rd_out),
        .o_result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // RV32M semantics computed with 64-bit host arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h rd %0d, want no completion", result, rd_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result",  result, e.res);
                chk("rd_addr", {27'd0, rd_out}, {27'd0, e.rd});
                chk("we",      {31'd0, we}, {31'd0, (e.rd != 5'd0)});
                chk("latency", cyc, e.due);
            end
        end else begin
            if (we) chk("we_without_done", {31'd0, we}, 32'd0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic start_raw(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        wait_idle();
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd_addr = 5'($urandom);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        exp_t e;
        wait_idle();
        e.res = ref_model(f, a, b);
        e.rd  = rd;
        e.due = cyc + 1 + W;
        exp_q.push_back(e);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd_addr = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int          n;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd",     {27'd0, rd_out}, 32'd0);
        rst = 1'b0;

        // Directed arithmetic cases, including the special-case results.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(3'd5, 32'd100, 32'd7, 5'd7);
        issue(3'd7, 32'd100, 32'd7, 5'd8);
        issue(3'd5, 32'd5, 32'd0, 5'd9);
        issue(3'd6, 32'd5, 32'd0, 5'd10);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        drain();
        chk("t1_value", ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

        // rd=0 completes without a write; a start pulse while busy is ignored.
        issue(3'd0, 32'd3, 32'd4, 5'd0);
        start = 1'b1; rs1 = 32'd99; rs2 = 32'd99; rd_addr = 5'd17;
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("rd0_result", result, 32'd12);

        // Flush mid-calculation: aborts silently, result retained.
        prev = result;
        start_raw(3'd5, 32'd1000, 32'd3, 5'd13);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", result, prev);
        repeat (40) @(negedge clk);
        chk("flush_result_hold", result, prev);
        issue(3'd7, 32'd1000, 32'd7, 5'd14);
        drain();

        // Flush beats a simultaneous start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_addr = 5'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_vs_start", {31'd0, busy}, 32'd0);

        // Flush raised during DONE: that pulse stands, then back to idle.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("done_flush_done", {31'd0, done}, 32'd0);
        chk("done_flush_busy", {31'd0, busy}, 32'd0);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), rand_op(), rand_op(), 5'($urandom));
        drain();

        // Reset mid-calculation clears every output.
        start_raw(3'd0, 32'd5, 32'd6, 5'd20);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_we",     {31'd0, we}, 32'd0);
        chk("midrst_rd",     {27'd0, rd_out}, 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        issue(3'd4, 32'd50, 32'hFFFF_FFF9, 5'd21);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
